// File: rtl/writeback_sequencer_pkg.sv
// Processor-wide constants and types shared by the write-back path.
// Holds the register-bank geometry, the buffered load entry, and a one-hot register decode.
package writeback_sequencer_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;
  localparam int ONEHOT_W   = NUM_REGS;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wc;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic [ONEHOT_W-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [ONEHOT_W-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/writeback_sequencer_fifo.sv
// Load-result FIFO: storage, pointers, occupancy count and the pending-destination mask.
// Each entry carries its own valid bit so the mask covers only live entries.
module wb_fifo
  import writeback_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_wc,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [REG_ADDR_W-1:0] head_wc,
  output logic [DATA_W-1:0]     head_data,
  output logic [PTR_W:0]        count,
  output logic                  full,
  output logic [ONEHOT_W-1:0]   pend
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign full      = (count == FULL_CNT);
  assign head_wc   = mem[rd_ptr].wc;
  assign head_data = mem[rd_ptr].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      // Clear before set: on a full push+pop both pointers share a slot and it must stay live.
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{wc: push_wc, data: push_data};
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend = pend | reg_onehot(mem[i].wc);
    end
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Write-side initiator for the 16x32 register bank: arbitrates ALU results against buffered
// loads, issues at most one registered write per cycle, and keeps per-register write order.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_wc,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_wc,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] wc,
  output logic [DATA_W-1:0]     wpc,
  output logic                  w_rb,
  output logic [ONEHOT_W-1:0]   pend
);

  // Handshake: a result transfers on a rising edge where valid && ready; the producer holds
  // valid, wc and data stable until then. Both readies are forced low while rst_n is low.

  logic [REG_ADDR_W-1:0] head_wc;
  logic [DATA_W-1:0]     head_data;
  logic [PTR_W:0]        count;
  logic                  full;
  logic                  conflict;
  logic                  pop;
  logic                  push;
  logic                  alu_accept;

  // An older load to the ALU's destination must land first, so it blocks the ALU.
  assign conflict   = alu_valid && pend[alu_wc];
  assign pop        = (count != '0) && (!alu_valid || full || conflict);
  assign alu_ready  = rst_n && !full && !conflict;
  assign mem_ready  = rst_n && (!full || pop);
  assign alu_accept = alu_valid && alu_ready;
  assign push       = mem_valid && mem_ready;

  wb_fifo #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_wc   (mem_wc),
    .push_data (mem_data),
    .pop       (pop),
    .head_wc   (head_wc),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .pend      (pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rb <= 1'b0;
      wc   <= '0;
      wpc  <= '0;
    end else if (alu_accept) begin
      w_rb <= 1'b1;
      wc   <= alu_wc;
      wpc  <= alu_data;
    end else if (pop) begin
      w_rb <= 1'b1;
      wc   <= head_wc;
      wpc  <= head_data;
    end else begin
      w_rb <= 1'b0;
    end
  end

endmodule

// File: doc/writeback_sequencer.md
Name: writeback_sequencer

Overview:
- Write-side initiator for the 16x32 register bank.
- Accepts results from the ALU path and the load (MEM) path, buffers load results, and issues at most one write per cycle.
- Drives the bank's WC/WPC/W_RB write port from registered outputs, preserving per-register write order.
- Exports a pending-write mask for hazard/stall logic in decode.

Parameters:
- DEPTH, 4, MEM result FIFO entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); FIFO pointer width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ALU_VALID  in  1  ALU result present.
- ALU_WC  in  4  ALU destination register.
- ALU_DATA  in  32  ALU result.
- ALU_READY  out  1  ALU result accepted this cycle when high with ALU_VALID.
- MEM_VALID  in  1  load result present.
- MEM_WC  in  4  load destination register.
- MEM_DATA  in  32  load data.
- MEM_READY  out  1  load result pushed into FIFO this cycle when high with MEM_VALID.
- WC  out  4  bank write address.
- WPC  out  32  bank write data.
- W_RB  out  1  bank write enable; the bank samples on the next CLK rising edge.
- PEND  out  16  bit i set while any FIFO entry targets register i.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, on RST_N.
- Reset values:
  - W_RB=0, WC=0, WPC=0.
  - FIFO empty, with rd_ptr=wr_ptr=0 and count=0.
  - PEND=0.
  - While RST_N is low, ALU_READY=0 and MEM_READY=0.
- Reset asserted mid-operation discards all buffered entries and any in-flight write. W_RB drops immediately (async).
- Handshake: a transfer occurs on a rising edge where VALID && READY. The producer must hold VALID, WC and DATA stable until accepted.
- The following signals are combinational from state plus same-cycle inputs:
  - full = (count == DEPTH).
  - conflict = ALU_VALID && (PEND[ALU_WC] == 1). This is the WAW guard: an older load to the same register must write first.
  - grant_fifo = (count != 0) && (!ALU_VALID || full || conflict).
  - pop = grant_fifo.
  - ALU_READY = !full && !conflict.
  - MEM_READY = !full || pop. A push is allowed into a full FIFO in the same cycle as a pop.
- Write selection at each rising edge, in priority order:
  - ALU accepted: W_RB<=1, WC<=ALU_WC, WPC<=ALU_DATA. ALU latency is 1 cycle from acceptance to W_RB high.
  - Else pop: W_RB<=1, WC<=FIFO head WC, WPC<=FIFO head data, rd_ptr++.
  - Else W_RB<=0; WC and WPC hold their values.
- ALU acceptance and pop are mutually exclusive by construction. ALU_READY low implies full or conflict, and both of those force grant_fifo whenever count>0.
- MEM path:
  - A push writes at wr_ptr, then wr_ptr++.
  - Minimum latency is 2 cycles from acceptance to W_RB high: FIFO stage, then output register.
  - Loads never bypass the FIFO.
- Pointers wrap modulo DEPTH. Count update: push&&!pop +1; pop&&!push -1; otherwise unchanged.
- PEND is the OR of the one-hot decodes of WC over all valid FIFO entries. It updates the cycle after a push or pop.
- A load that has been popped into the output register is no longer in PEND. Decode must treat WC/W_RB as the in-flight write.
- Simultaneous push and pop on an empty FIFO is impossible, because pop requires count != 0.
- Duplicate destinations inside the FIFO are legal. They are written in FIFO order.
- No write combining. Every accepted result produces exactly one W_RB pulse.
- Every register 0..15 is writable; there is no hardwired zero register.

Decomposition:
- Shared package (processor constants):
  - REG_ADDR_W=4, DATA_W=32, NUM_REGS=16.
  - Localparam for the one-hot decode width.
- Sub-module wb_fifo (parameter DEPTH): storage, pointers and count, push/pop, head outputs, and the PEND mask generation.
- Arbitration, the ready logic and the output register stay in writeback_sequencer.

Test Plan:
- Reset check: hold RST_N=0, then release with no traffic. Required: W_RB=0, WC=0, WPC=0, PEND=0; ALU_READY=1 and MEM_READY=1 one cycle after release.
- ALU only: ALU_VALID=1, ALU_WC=3, ALU_DATA=32'hDEADBEEF for 1 cycle. Required: next cycle W_RB=1, WC=3, WPC=32'hDEADBEEF; the cycle after, W_RB=0.
- Load during ALU burst:
  - MEM_VALID pulse with WC=5, data 32'h11, while ALU_VALID=1 continuously to WC=7.
  - Required: PEND[5]=1 and the ALU writes continue each cycle.
  - Drop ALU_VALID. Required: the reg-5 write appears 1 cycle later and PEND returns to 0.
- WAW guard:
  - Push a load to WC=9 (data 32'hA) while the ALU is busy, then present ALU WC=9, data 32'hB.
  - Required: ALU_READY=0 until the load pops; write order is reg9=A then reg9=B.
- Full FIFO:
  - Push DEPTH=4 loads (WC=1..4) while ALU_VALID=1 to WC=8.
  - Required: after the 4th push, ALU_READY=0 and a pop occurs.
  - A 5th MEM_VALID is accepted in the same cycle as that pop.
  - All 5 loads are written in order, with no loss or duplication.
- Async reset mid-stream: assert RST_N=0 with 3 entries buffered and W_RB=1. Required: W_RB=0 immediately, and no buffered write appears after release.
